// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for the DCache and IO buses.
// Ports: EX/MEM access in (is_dmem/io_info/size/sign/addr/wdata/flush), dc_*/io_* handshakes, mem_stall, ld_data/ld_valid/ale/io_err.
module mem_access_ctrl #(
  parameter int WORD       = 32,
  parameter int IO_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      is_dmem,
  input  logic            io_info,
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic            flush,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] wdata,
  input  logic            dc_addr_ok,
  input  logic            dc_data_ok,
  input  logic [WORD-1:0] dc_rdata,
  input  logic            io_ready,
  input  logic [WORD-1:0] io_rdata,
  output logic            dc_req,
  output logic            dc_we,
  output logic [WORD-1:0] dc_addr,
  output logic [WORD-1:0] dc_wdata,
  output logic [3:0]      dc_wstrb,
  output logic            io_req,
  output logic            io_we,
  output logic [WORD-1:0] io_addr,
  output logic [WORD-1:0] io_wdata,
  output logic [3:0]      io_wstrb,
  output logic            mem_stall,
  output logic [WORD-1:0] ld_data,
  output logic            ld_valid,
  output logic            ale,
  output logic            io_err
);

  localparam int CW = $clog2(IO_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(IO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DC_REQ,
    DC_WAIT,
    IO_REQ,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]   cnt;
  logic            kill;
  logic [WORD-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic [3:0]      req_strb;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_sign;

  logic            start;
  logic            misal;
  logic            busy;
  logic            killed;
  logic [3:0]      strb_nx;
  logic [WORD-1:0] wdata_nx;
  logic            cap;
  logic            timeout;
  logic [WORD-1:0] rdata_sel;
  logic [WORD-1:0] shifted;
  logic [WORD-1:0] ext;

  // Request decode and store lane formatting.
  always_comb begin
    start = is_dmem[1] & ~flush;
    misal = ((size == 2'b01) & addr[0]) |
            (size[1] & (|addr[1:0]));
    unique case (size)
      2'b00: begin
        strb_nx  = 4'b0001 << addr[1:0];
        wdata_nx = {(WORD/8){wdata[7:0]}};
      end
      2'b01: begin
        strb_nx  = 4'b0011 << {addr[1], 1'b0};
        wdata_nx = {(WORD/16){wdata[15:0]}};
      end
      default: begin
        strb_nx  = 4'b1111;
        wdata_nx = wdata;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx  = state;
    cap       = 1'b0;
    timeout   = 1'b0;
    rdata_sel = dc_rdata;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (misal)        state_nx = DONE;
          else if (io_info) state_nx = IO_REQ;
          else              state_nx = DC_REQ;
        end
      end
      DC_REQ: begin
        if (dc_addr_ok) begin
          if (dc_data_ok) begin
            state_nx = DONE;
            cap      = 1'b1;
          end else begin
            state_nx = DC_WAIT;
          end
        end
      end
      DC_WAIT: begin
        if (dc_data_ok) begin
          state_nx = DONE;
          cap      = 1'b1;
        end
      end
      IO_REQ: begin
        rdata_sel = io_rdata;
        // io_ready wins over a timeout in the same cycle.
        if (io_ready) begin
          state_nx = DONE;
          cap      = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_nx = DONE;
          timeout  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Load alignment and extension from the latched request.
  always_comb begin
    shifted = rdata_sel >> {req_addr[1:0], 3'b000};
    unique case (req_size)
      2'b00:   ext = {{(WORD-8){req_sign & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{(WORD-16){req_sign & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign busy   = (state == DC_REQ) | (state == DC_WAIT) | (state == IO_REQ);
  // A flush on the completing cycle must also suppress the result.
  assign killed = kill | flush;

  assign mem_stall = ((state == IDLE) & start) | busy;

  assign dc_we    = dc_req & req_we;
  assign dc_addr  = {req_addr[WORD-1:2], 2'b00};
  assign dc_wdata = req_wdata;
  assign dc_wstrb = req_strb;
  assign io_we    = io_req & req_we;
  assign io_addr  = {req_addr[WORD-1:2], 2'b00};
  assign io_wdata = req_wdata;
  assign io_wstrb = req_strb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      kill     <= 1'b0;
      ld_data  <= '0;
      ld_valid <= 1'b0;
      ale      <= 1'b0;
      io_err   <= 1'b0;
      dc_req   <= 1'b0;
      io_req   <= 1'b0;
    end else begin
      state    <= state_nx;
      dc_req   <= (state_nx == DC_REQ);
      io_req   <= (state_nx == IO_REQ);
      kill     <= busy & (kill | flush);
      ld_valid <= 1'b0;
      ale      <= 1'b0;
      io_err   <= 1'b0;
      if ((state == IO_REQ) && (state_nx == IO_REQ))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if ((state == IDLE) && start && misal)
        ale <= 1'b1;
      if (cap && !req_we) begin
        ld_data  <= ext;
        ld_valid <= ~killed;
      end
      if (timeout) begin
        ld_data <= '0;
        io_err  <= ~killed;
      end
    end
  end

  // Request fields stay frozen for the whole bus transaction.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      req_addr  <= addr;
      req_wdata <= wdata_nx;
      req_strb  <= strb_nx;
      req_we    <= is_dmem[0];
      req_size  <= size;
      req_sign  <= sign;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector bench for mem_access_ctrl.
// Table of DCache accesses plus sequences for IO, flush, reset and timeout.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  is_dmem;
  logic        io_info;
  logic [1:0]  size;
  logic        sign;
  logic        flush;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dc_addr_ok;
  logic        dc_data_ok;
  logic [31:0] dc_rdata;
  logic        io_ready;
  logic [31:0] io_rdata;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        mem_stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ale;
  logic        io_err;

  mem_access_ctrl #(.WORD(32), .IO_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .is_dmem(is_dmem), .io_info(io_info),
    .size(size), .sign(sign), .flush(flush), .addr(addr), .wdata(wdata),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .io_ready(io_ready), .io_rdata(io_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .mem_stall(mem_stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .ale(ale), .io_err(io_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic [3:0]  strb;
    logic [31:0] ewd;
    logic [31:0] eld;
  } vec_t;

  vec_t tv[13];
  int total = 0;
  int bad = 0;

  int          r_stall;
  int          r_req;
  logic        r_valid;
  logic [31:0] r_ld;
  logic        r_ale;
  logic        r_err;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // One access from IDLE through DONE; the bench plays both slaves.
  task automatic run_acc(input vec_t v, input bit io, input int rdy_after,
                         input int dwait, input int flush_at,
                         input bit same, input string nm);
    int phase;
    int wcnt;
    bit done;
    r_stall = 0; r_req = 0; r_valid = 0; r_ld = '0; r_ale = 0;
    r_err = 0; r_we = 0; r_addr = '0; r_wdata = '0; r_strb = '0;
    phase = 0; wcnt = 0; done = 0;
    is_dmem = {1'b1, v.st}; io_info = io; size = v.sz; sign = v.sg;
    addr = v.a; wdata = v.wd;
    for (int c = 0; c < 40 && !done; c++) begin
      flush = (c == flush_at);
      dc_addr_ok = 0; dc_data_ok = 0; io_ready = 0;
      #1;
      if (mem_stall) r_stall++;
      if (dc_req || io_req) begin
        r_req++;
        r_we    = dc_req ? dc_we    : io_we;
        r_addr  = dc_req ? dc_addr  : io_addr;
        r_wdata = dc_req ? dc_wdata : io_wdata;
        r_strb  = dc_req ? dc_wstrb : io_wstrb;
      end
      if (io_req) begin
        if (r_req == rdy_after) begin
          io_ready = 1; io_rdata = v.rd;
        end
      end else if (dc_req) begin
        dc_addr_ok = 1;
        phase = 1;
        if (same) begin
          dc_data_ok = 1; dc_rdata = v.rd; phase = 2;
        end
      end else if (phase == 1) begin
        wcnt++;
        if (wcnt >= dwait) begin
          dc_data_ok = 1; dc_rdata = v.rd; phase = 2;
        end
      end
      if (c > 0 && !mem_stall) begin
        done = 1;
        r_valid = ld_valid; r_ld = ld_data; r_ale = ale; r_err = io_err;
        is_dmem = 2'b00;
      end
      @(posedge clk); #1;
    end
    flush = 0; dc_addr_ok = 0; dc_data_ok = 0; io_ready = 0;
    is_dmem = 2'b00;
    chk({nm, " done"}, 32'(done), 32'd1);
    #1;
    chk({nm, " pulse_end"}, {29'd0, ld_valid, ale, io_err}, 32'd0);
  endtask

  task automatic check_res(input string nm, input int e_stall,
                           input int e_req, input logic e_valid,
                           input logic e_ale, input logic e_err,
                           input bit chk_ld, input logic [31:0] e_ld);
    chk({nm, " stall"}, 32'(r_stall), 32'(e_stall));
    chk({nm, " reqs"}, 32'(r_req), 32'(e_req));
    chk({nm, " valid"}, 32'(r_valid), 32'(e_valid));
    chk({nm, " ale"}, 32'(r_ale), 32'(e_ale));
    chk({nm, " io_err"}, 32'(r_err), 32'(e_err));
    if (chk_ld) chk({nm, " ld_data"}, r_ld, e_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    string nm;
    tv[0]  = '{0, 2'b10, 0, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, 0, 4'hF, 32'h0, 32'hDEAD_BEEF};
    tv[1]  = '{0, 2'b00, 1, 32'h1000_0003, 32'h0, 32'h80FF_1234, 0, 4'h8, 32'h0, 32'hFFFF_FF80};
    tv[2]  = '{0, 2'b00, 0, 32'h1000_0003, 32'h0, 32'h80FF_1234, 0, 4'h8, 32'h0, 32'h0000_0080};
    tv[3]  = '{0, 2'b01, 1, 32'h1000_0002, 32'h0, 32'h80FF_1234, 0, 4'hC, 32'h0, 32'hFFFF_80FF};
    tv[4]  = '{0, 2'b01, 0, 32'h1000_0000, 32'h0, 32'h80FF_1234, 0, 4'h3, 32'h0, 32'h0000_1234};
    tv[5]  = '{0, 2'b00, 1, 32'h1000_0001, 32'h0, 32'h80FF_1234, 0, 4'h2, 32'h0, 32'h0000_0012};
    tv[6]  = '{1, 2'b01, 0, 32'h1000_0002, 32'h0000_ABCD, 32'h0, 0, 4'hC, 32'hABCD_ABCD, 32'h0};
    tv[7]  = '{1, 2'b00, 0, 32'h1000_0001, 32'h1234_5678, 32'h0, 0, 4'h2, 32'h7878_7878, 32'h0};
    tv[8]  = '{1, 2'b10, 0, 32'h1000_000C, 32'hCAFE_F00D, 32'h0, 0, 4'hF, 32'hCAFE_F00D, 32'h0};
    tv[9]  = '{0, 2'b11, 0, 32'h1000_0004, 32'h0, 32'h0123_4567, 0, 4'hF, 32'h0, 32'h0123_4567};
    tv[10] = '{0, 2'b10, 0, 32'h1000_0001, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0};
    tv[11] = '{1, 2'b01, 0, 32'h1000_0003, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0};
    tv[12] = '{1, 2'b00, 0, 32'h1000_0003, 32'h0000_00AB, 32'h0, 0, 4'h8, 32'hABAB_ABAB, 32'h0};

    rst = 1; is_dmem = 0; io_info = 0; size = 0; sign = 0; flush = 0;
    addr = 0; wdata = 0; dc_addr_ok = 0; dc_data_ok = 0; dc_rdata = 0;
    io_ready = 0; io_rdata = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst outs", {25'd0, dc_req, io_req, mem_stall, ld_valid, ale,
                     io_err, 1'b0}, 32'd0);
    chk("rst ld_data", ld_data, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      v = tv[i];
      nm = $sformatf("v%0d", i);
      run_acc(v, 0, -1, 1, -1, 0, nm);
      check_res(nm, v.mis ? 1 : 3, v.mis ? 0 : 1, !v.st && !v.mis,
                v.mis, 0, !v.st && !v.mis, v.eld);
      if (!v.mis) begin
        chk({nm, " addr"}, r_addr, {v.a[31:2], 2'b00});
        chk({nm, " we"}, 32'(r_we), 32'(v.st));
      end
      if (v.st && !v.mis) begin
        chk({nm, " wstrb"}, 32'(r_strb), 32'(v.strb));
        chk({nm, " wdata"}, r_wdata, v.ewd);
      end
    end

    // Same-cycle addr_ok and data_ok.
    run_acc(tv[0], 0, -1, 1, -1, 1, "same");
    check_res("same", 2, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);

    // IO byte load completing on the second request cycle.
    v = '{0, 2'b00, 0, 32'h2000_0002, 32'h0, 32'h1122_3344, 0, 4'h4, 32'h0, 32'h0000_0022};
    run_acc(v, 1, 2, 1, -1, 0, "io_ld");
    check_res("io_ld", 3, 2, 1, 0, 0, 1, 32'h0000_0022);
    chk("io_ld addr", r_addr, 32'h2000_0000);

    // IO word store.
    v = '{1, 2'b10, 0, 32'h2000_0004, 32'h0BAD_F00D, 32'h0, 0, 4'hF, 32'h0BAD_F00D, 32'h0};
    run_acc(v, 1, 1, 1, -1, 0, "io_st");
    check_res("io_st", 2, 1, 0, 0, 0, 0, 32'h0);
    chk("io_st we", 32'(r_we), 32'd1);
    chk("io_st wstrb", 32'(r_strb), 32'hF);
    chk("io_st wdata", r_wdata, 32'h0BAD_F00D);

    // IO load with no io_ready: four request cycles then io_err.
    v = '{0, 2'b10, 0, 32'h2000_0008, 32'h0, 32'h5555_5555, 0, 4'hF, 32'h0, 32'h0};
    run_acc(v, 1, -1, 1, -1, 0, "io_to");
    check_res("io_to", 5, 4, 0, 0, 1, 1, 32'h0);

    // Flush during DC_WAIT: handshake completes, no ld_valid.
    run_acc(tv[0], 0, -1, 2, 2, 0, "flush_wait");
    check_res("flush_wait", 4, 1, 0, 0, 0, 0, 32'h0);
    run_acc(tv[1], 0, -1, 1, -1, 0, "after_flush");
    check_res("after_flush", 3, 1, 1, 0, 0, 1, 32'hFFFF_FF80);

    // Flush in IDLE: access never starts.
    is_dmem = 2'b10; io_info = 0; size = 2'b10; addr = 32'h1000_0000;
    flush = 1;
    #1;
    chk("idle_flush stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #2;
    chk("idle_flush req", {30'd0, dc_req, io_req}, 32'd0);
    flush = 0; is_dmem = 2'b00;
    @(posedge clk); #1;

    // Reset in the middle of an IO request.
    is_dmem = 2'b10; io_info = 1; size = 2'b10; addr = 32'h2000_0000;
    @(posedge clk); #2;
    chk("rst_io req_on", 32'(io_req), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; is_dmem = 2'b00; io_info = 0;
    #1;
    chk("rst_io req_off", {30'd0, dc_req, io_req}, 32'd0);
    chk("rst_io stall", 32'(mem_stall), 32'd0);
    chk("rst_io flags", {29'd0, ld_valid, ale, io_err}, 32'd0);
    @(posedge clk); #1;
    run_acc(tv[9], 0, -1, 1, -1, 0, "post_rst");
    check_res("post_rst", 3, 1, 1, 0, 0, 1, 32'h0123_4567);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
